mem_game_seq: RTL
=================

MEM_GAME_SEQ -- requirements
Module: mem_game_seq

Interface
REQ-001 SHALL have parameter SYM_W, default 4, symbol width in bits (1..16).
REQ-002 SHALL have parameter MAX_LEN, default 8, maximum sequence length (1..16).
REQ-003 SHALL have parameter TICK_DIV, default 1000000, clk cycles per internal tick.
REQ-004 SHALL have parameter SHOW_TICKS, default 100, ticks each displayed item is held.
REQ-005 SHALL have ports: clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: start  in  1  one-cycle pulse, new round; load  in  1  one-cycle pulse, commit guess.
REQ-007 SHALL have ports: predict  in  SYM_W  player guess; seq_len  in  5  requested length.
REQ-008 SHALL have ports: led  out  2*SYM_W  display; busy  out  1  round active; result  out  2  00 none / 01 exact / 10 permutation / 11 fail.

Function
REQ-009 SHALL use states IDLE, GEN, SHOW, MARK, READ, JUDGE, RESULT; single clock domain, no derived clocks.
REQ-010 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) stepping every clk; seed 16'hACE1; never all-zero.
REQ-011 SHALL, on start in IDLE or RESULT, latch length L = seq_len clamped to 1..MAX_LEN (0 -> 1), clear result, enter GEN next cycle.
REQ-012 GEN SHALL store lfsr[SYM_W-1:0] as sym[i], one per cycle, i = 0..L-1 (L cycles), then enter SHOW.
REQ-013 Tick counter SHALL clear on entry to SHOW/MARK and pulse once every TICK_DIV clk cycles.
REQ-014 SHOW SHALL drive led = {SYM_W zeros, sym[k]} for SHOW_TICKS ticks per k = 0..L-1, then enter MARK.
REQ-015 MARK SHALL drive led all-ones for SHOW_TICKS ticks, then enter READ with guess index j = 0.
REQ-016 READ SHALL drive led = {j zero-extended to SYM_W, predict} combinationally from predict.
REQ-017 load in READ SHALL store take[j] = predict, j++; the L-th load SHALL enter JUDGE next cycle.
REQ-018 JUDGE SHALL take exactly L cycles, checking per cycle i: count of sym[i] in sym == count of sym[i] in take.
REQ-019 result SHALL be 01 if take[i]==sym[i] for all i<L; else 10 if every JUDGE check passed; else 11; set on RESULT entry.
REQ-020 RESULT SHALL drive led all-ones (01), alternating 1010.. with MSB=1 (10), or lower SYM_W bits ones (11); held until next start.
REQ-021 busy SHALL be 1 in GEN..JUDGE, 0 in IDLE and RESULT.
REQ-022 start SHALL be ignored while busy; load SHALL be ignored outside READ; start and load in the same READ cycle: load acts, start ignored.
REQ-023 Duplicate symbols SHALL be legal; permutation check is multiset equality.

Reset
REQ-024 reset SHALL force IDLE, led=0, result=00, busy=0, LFSR=16'hACE1, all indices and tick counter 0, at any state.
REQ-025 sym/take storage SHALL NOT need reset; it SHALL be unobservable until rewritten.

Configuration
REQ-026 With MEM_GAME_LEVEL_EN defined: internal level starts at clamped seq_len on first start; result 01 increments level (saturate MAX_LEN); result 11 reloads seq_len; later starts use level.
REQ-027 Without MEM_GAME_LEVEL_EN: every start uses clamped seq_len; no level register exists.

Verification (TICK_DIV=2, SHOW_TICKS=3, SYM_W=4, MAX_LEN=8)
REQ-028 Reset, start, seq_len=3 -> busy 1 cycle after start; 3 GEN cycles; each symbol on led[3:0] for 6 clk; led=8'hFF for 6 clk; READ.
REQ-029 Load the three shown symbols in order -> JUDGE 3 cycles; result=01, led=8'hFF.
REQ-030 Load shown symbols rotated (s1,s2,s0) with distinct symbols -> result=10, led=8'hAA; load one wrong symbol -> result=11, led=8'h0F.
REQ-031 seq_len=0 -> L=1; seq_len=20 -> L=8; start during SHOW -> no effect; reset asserted in READ -> led=0, IDLE same cycle.
REQ-032 MEM_GAME_LEVEL_EN, seq_len=2: win -> next round L=3; win at L=8 -> stays 8; fail -> next round L=2.

Source files
------------

// File: rtl/mem_game_seq.sv
// Memory game: LFSR-generated symbol sequence, shown per tick, read back and judged; result held until next start.
// Inputs are single-cycle pulses with no backpressure; define MEM_GAME_LEVEL_EN for the adaptive round-length level.
module mem_game_seq #(
    parameter int SYM_W      = 4,
    parameter int MAX_LEN    = 8,
    parameter int TICK_DIV   = 1000000,
    parameter int SHOW_TICKS = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               load,
    input  logic [SYM_W-1:0]   predict,
    input  logic [4:0]         seq_len,
    output logic [2*SYM_W-1:0] led,
    output logic               busy,
    output logic [1:0]         result
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;
    localparam logic [4:0] MAX_L = 5'(MAX_LEN);
    localparam logic [2*SYM_W-1:0] ALT = {SYM_W{2'b10}};

    typedef enum logic [2:0] {IDLE, GEN, SHOW, MARK, READ, JUDGE, RESULT} state_t;

    state_t            state, state_nxt;
    logic [15:0]       lfsr;
    logic [4:0]        len, idx, seq_l, start_len, cnt_sym, cnt_take;
    logic [TW-1:0]     tick_cnt;
    logic [SW-1:0]     show_cnt;
    logic              exact_ok, perm_ok, tick, hold_done, last, start_ok;
    logic              cur_exact, cur_perm;
    logic [1:0]        verdict;
    logic [2*SYM_W-1:0] res_led;
    logic [SYM_W-1:0]  sym  [MAX_LEN];
    logic [SYM_W-1:0]  take [MAX_LEN];

    always_comb begin
        seq_l = seq_len;
        if (seq_len == 5'd0)
            seq_l = 5'd1;
        else if (seq_len > MAX_L)
            seq_l = MAX_L;
    end

    assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
    assign hold_done = tick && (show_cnt == SW'(SHOW_TICKS - 1));
    assign last      = (idx == len - 5'd1);
    assign start_ok  = start && (state == IDLE || state == RESULT);

    // One JUDGE step: multiplicity of sym[idx] in the shown sequence vs. in the guesses.
    always_comb begin
        cnt_sym  = '0;
        cnt_take = '0;
        for (int n = 0; n < MAX_LEN; n++) begin
            if (5'(n) < len) begin
                if (sym[n] == sym[idx[IW-1:0]])  cnt_sym  = cnt_sym + 5'd1;
                if (take[n] == sym[idx[IW-1:0]]) cnt_take = cnt_take + 5'd1;
            end
        end
        cur_exact = (take[idx[IW-1:0]] == sym[idx[IW-1:0]]);
        cur_perm  = (cnt_sym == cnt_take);
        if (exact_ok && cur_exact)
            verdict = 2'b01;
        else if (perm_ok && cur_perm)
            verdict = 2'b10;
        else
            verdict = 2'b11;
    end

    always_comb begin
        case (result)
            2'b01:   res_led = '1;
            2'b10:   res_led = ALT;
            2'b11:   res_led = {{SYM_W{1'b0}}, {SYM_W{1'b1}}};
            default: res_led = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        led       = '0;
        busy      = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = GEN;
            GEN: begin
                busy = 1'b1;
                if (last) state_nxt = SHOW;
            end
            SHOW: begin
                busy = 1'b1;
                led  = {{SYM_W{1'b0}}, sym[idx[IW-1:0]]};
                if (hold_done && last) state_nxt = MARK;
            end
            MARK: begin
                busy = 1'b1;
                led  = '1;
                if (hold_done) state_nxt = READ;
            end
            READ: begin
                busy = 1'b1;
                led  = {SYM_W'(idx), predict};
                if (load && last) state_nxt = JUDGE;
            end
            JUDGE: begin
                busy = 1'b1;
                if (last) state_nxt = RESULT;
            end
            RESULT: begin
                led = res_led;
                if (start) state_nxt = GEN;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MEM_GAME_LEVEL_EN
    logic [4:0] level;
    logic       level_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level     <= '0;
            level_vld <= 1'b0;
        end else begin
            if (start_ok && !level_vld) begin
                level     <= seq_l;
                level_vld <= 1'b1;
            end
            if (state == JUDGE && last) begin
                if (verdict == 2'b01)
                    level <= (level == MAX_L) ? level : level + 5'd1;
                else if (verdict == 2'b11)
                    level <= seq_l;
            end
        end
    end

    assign start_len = level_vld ? level : seq_l;
`else
    assign start_len = seq_l;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr     <= 16'hACE1;
            len      <= 5'd1;
            idx      <= '0;
            tick_cnt <= '0;
            show_cnt <= '0;
            exact_ok <= 1'b1;
            perm_ok  <= 1'b1;
            result   <= 2'b00;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

            if (state_nxt != state || !(state == SHOW || state == MARK) || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + TW'(1);

            if (state_nxt != state || hold_done)
                show_cnt <= '0;
            else if (tick)
                show_cnt <= show_cnt + SW'(1);

            // idx walks the sequence: GEN write, SHOW display, READ guess, JUDGE check.
            if (state_nxt != state)
                idx <= '0;
            else if (state == GEN || state == JUDGE || (state == SHOW && hold_done) ||
                     (state == READ && load))
                idx <= idx + 5'd1;

            if (start_ok) begin
                len      <= start_len;
                result   <= 2'b00;
                exact_ok <= 1'b1;
                perm_ok  <= 1'b1;
            end

            if (state == JUDGE) begin
                exact_ok <= exact_ok & cur_exact;
                perm_ok  <= perm_ok & cur_perm;
                if (last) result <= verdict;
            end
        end
    end

    // Sequence and guess storage is written before every read in a round, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == GEN)
            sym[idx[IW-1:0]] <= lfsr[SYM_W-1:0];
        if (state == READ && load)
            take[idx[IW-1:0]] <= predict;
    end

endmodule
